cmd_cntrl_q: RTL and testbench
==============================

Name: cmd_cntrl_q

Overview:
- Parametrised successor to the single-destination follower command controller.
- Holds a FIFO queue of up to DEPTH destination station IDs. It pops the head when a matching station ID is read, and stops only when the queue drains.
- Drives go and in_transit to the motion controller, and a parametrised piezo PWM (buzz, buzz_n) while motion is blocked.
- Sits between the command UART (cmd, cmd_rdy) and the station-ID reader (ID, ID_vld).

Parameters:
- IDW, 6, station ID width. cmd is IDW+2 bits and ID is IDW+2 bits; only the low IDW bits of ID are compared.
- DEPTH, 4, destination queue depth (>=2).
- BUZZ_PERIOD, 12500, piezo period in clk cycles (4 kHz at 50 MHz).
- BUZZ_HIGH, 6250, cycles per period that buzz is high (< BUZZ_PERIOD).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  IDW+2  command; [IDW+1:IDW] opcode, [IDW-1:0] destination
- cmd_rdy  in  1  cmd valid, held until cleared
- clr_cmd_rdy  out  1  consume pulse for cmd_rdy
- ID  in  IDW+2  station ID read
- ID_vld  in  1  ID valid, held until cleared
- clr_ID_vld  out  1  consume pulse for ID_vld
- OK2Move  in  1  obstacle-free indication
- in_transit  out  1  registered; queue active
- go  out  1  in_transit & OK2Move, combinational
- buzz  out  1  piezo drive
- buzz_n  out  1  complementary piezo drive
- dest_id  out  IDW  queue head; 0 when queue is empty
- q_cnt  out  $clog2(DEPTH+1)  queue occupancy
- q_ovf  out  1  one-cycle pulse when an append is dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: IDLE, queue empty, q_cnt=0, dest_id=0, in_transit=0, buzz=0, buzz_n=0, buzz counter=0, q_ovf=0.
- States: IDLE and TRANSIT. in_transit = (state==TRANSIT), registered.
- Command consumption: every cycle with cmd_rdy=1, clr_cmd_rdy=1 (combinational, same cycle). The command takes effect at that clock edge.
- Opcode 00 STOP: flush the queue, go to IDLE.
- Opcode 01 GOTO: flush the queue and write the destination as the single entry (q_cnt=1), go to TRANSIT.
- Opcode 10 APPEND: push to the tail.
  - If the queue was empty, go to TRANSIT.
  - If q_cnt==DEPTH, the entry is dropped, q_ovf pulses for 1 cycle, and state is unchanged.
- Opcode 11: reserved. Consumed with no effect.
- ID consumption: every cycle with ID_vld=1 and cmd_rdy=0, clr_ID_vld=1.
  - In IDLE the ID is discarded.
  - In TRANSIT, if ID[IDW-1:0]==dest_id, pop the head.
  - If that pop empties the queue (q_cnt was 1), go to IDLE; in_transit falls the next cycle.
  - A mismatch is discarded; stay in TRANSIT.
- Simultaneous cmd_rdy and ID_vld: the command has priority. clr_ID_vld=0 that cycle and the ID is serviced on a later cycle.
- Latency: in_transit rises 1 cycle after the edge that accepts GOTO, or APPEND to an empty queue. It falls 1 cycle after the accepting edge of STOP or of the final matching ID.
- Queue: circular buffer with wrapping head/tail pointers. q_cnt saturates at 0 and DEPTH; it never underflows or overflows.
- Buzzer:
  - en = in_transit & ~OK2Move.
  - When en=0: counter held at 0, buzz=0, buzz_n=0.
  - When en=1: counter counts 0..BUZZ_PERIOD-1 and wraps to 0.
  - buzz is registered: 1 when counter < BUZZ_HIGH. buzz_n = ~buzz while en=1.
  - Each en rising edge restarts at counter 0, so buzz=1 on the first cycle after en is sampled.
- Reset mid-operation returns all state to reset values immediately, regardless of any pending cmd_rdy or ID_vld.

Test Plan:
- Reset, then GOTO 0x05 -> clr_cmd_rdy pulses 1 cycle; in_transit=1 next cycle; dest_id=5, q_cnt=1. ID 0x05 -> pop; in_transit=0 next cycle, q_cnt=0.
- GOTO 3, APPEND 7, APPEND 9 -> q_cnt=3. ID 3 -> dest_id=7. ID 4 -> clr_ID_vld pulses, no change. ID 7 -> dest_id=9. ID 9 -> IDLE.
- DEPTH=4: GOTO 1 + APPEND x3 fills the queue. A 5th APPEND -> q_ovf pulses once, q_cnt stays 4, head stays 1. Pop through all entries -> pointer wrap yields order 1,2,3,4.
- cmd_rdy and ID_vld asserted together in TRANSIT -> only clr_cmd_rdy pulses; clr_ID_vld follows the next cycle.
- In TRANSIT, drop OK2Move for 30000 cycles with BUZZ_PERIOD=12500 -> go=0; buzz high 6250 and low 6250 cycles per period; buzz_n=~buzz. Raise OK2Move -> buzz=buzz_n=0 within 1 cycle.
- STOP mid-transit with q_cnt=3 -> q_cnt=0 and in_transit=0 next cycle. Assert rst_n low mid-buzz -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cmd_cntrl_q.sv
// Follower command controller with a FIFO of destination station IDs.
// Pops the head on a matching station ID; drives go/in_transit and a piezo PWM while blocked.
module cmd_cntrl_q #(
  parameter int unsigned IDW         = 6,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned BUZZ_PERIOD = 12500,
  parameter int unsigned BUZZ_HIGH   = 6250
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IDW+1:0]               cmd,
  input  logic                         cmd_rdy,
  output logic                         clr_cmd_rdy,
  input  logic [IDW+1:0]               ID,
  input  logic                         ID_vld,
  output logic                         clr_ID_vld,
  input  logic                         OK2Move,
  output logic                         in_transit,
  output logic                         go,
  output logic                         buzz,
  output logic                         buzz_n,
  output logic [IDW-1:0]               dest_id,
  output logic [$clog2(DEPTH+1)-1:0]   q_cnt,
  output logic                         q_ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(BUZZ_PERIOD);

  localparam logic [PW-1:0] PtrMax   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CntFull  = CW'(DEPTH);
  localparam logic [BW-1:0] BuzzLast = BW'(BUZZ_PERIOD - 1);
  localparam logic [BW-1:0] BuzzHigh = BW'(BUZZ_HIGH);

  localparam logic [1:0] OpStop   = 2'b00;
  localparam logic [1:0] OpGoto   = 2'b01;
  localparam logic [1:0] OpAppend = 2'b10;

  typedef enum logic {StIdle, StTransit} state_e;

  state_e          state_q;
  logic [IDW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic [BW-1:0]   bcnt_q;
  logic            buzz_q, buzz_n_q;

  logic [1:0]      op;
  logic [IDW-1:0]  dst;
  logic            id_take, id_match, buzz_en, buzz_hi;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PtrMax) ? '0 : p + PW'(1);
  endfunction

  assign op  = cmd[IDW+1:IDW];
  assign dst = cmd[IDW-1:0];

  // Command always wins; an ID waiting alongside it is serviced on a later cycle.
  assign id_take  = ID_vld & ~cmd_rdy;
  assign id_match = id_take && (state_q == StTransit) && (cnt_q != '0) &&
                    (ID[IDW-1:0] == dest_id);

  assign clr_cmd_rdy = cmd_rdy;
  assign clr_ID_vld  = id_take;
  assign in_transit  = (state_q == StTransit);
  assign go          = in_transit & OK2Move;
  assign dest_id     = (cnt_q == '0) ? '0 : mem_q[head_q];
  assign q_cnt       = cnt_q;
  assign q_ovf       = ovf_q;
  assign buzz        = buzz_q;
  assign buzz_n      = buzz_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ovf_q <= 1'b0;
      if (cmd_rdy) begin
        case (op)
          OpStop: begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
          end
          OpGoto: begin
            state_q  <= StTransit;
            mem_q[0] <= dst;
            head_q   <= '0;
            tail_q   <= ptr_inc('0);
            cnt_q    <= CW'(1);
          end
          OpAppend: begin
            if (cnt_q == CntFull) begin
              ovf_q <= 1'b1;
            end else begin
              state_q       <= StTransit;
              mem_q[tail_q] <= dst;
              tail_q        <= ptr_inc(tail_q);
              cnt_q         <= cnt_q + CW'(1);
            end
          end
          default: ;
        endcase
      end else if (id_match) begin
        head_q <= ptr_inc(head_q);
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_q <= StIdle;
      end
    end
  end

  // Piezo: counter restarts at 0 whenever motion becomes blocked.
  assign buzz_en = in_transit & ~OK2Move;
  assign buzz_hi = (bcnt_q < BuzzHigh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q   <= '0;
      buzz_q   <= 1'b0;
      buzz_n_q <= 1'b0;
    end else if (!buzz_en) begin
      bcnt_q   <= '0;
      buzz_q   <= 1'b0;
      buzz_n_q <= 1'b0;
    end else begin
      buzz_q   <= buzz_hi;
      buzz_n_q <= ~buzz_hi;
      bcnt_q   <= (bcnt_q == BuzzLast) ? '0 : bcnt_q + BW'(1);
    end
  end

endmodule

// File: tb/tb_cmd_cntrl_q.sv
// Directed bench for cmd_cntrl_q: table-driven queue/handshake vectors plus
// hand-written priority, buzzer and asynchronous-reset sequences.
module tb_cmd_cntrl_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic       OK2Move;
  logic       in_transit;
  logic       go;
  logic       buzz;
  logic       buzz_n;
  logic [5:0] dest_id;
  logic [2:0] q_cnt;
  logic       q_ovf;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] STOP = 2'b00, GOTO = 2'b01, APND = 2'b10, RSVD = 2'b11;

  cmd_cntrl_q #(
    .IDW(6), .DEPTH(4), .BUZZ_PERIOD(12500), .BUZZ_HIGH(6250)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
    .in_transit(in_transit), .go(go), .buzz(buzz), .buzz_n(buzz_n),
    .dest_id(dest_id), .q_cnt(q_cnt), .q_ovf(q_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       crdy;
    logic [7:0] cmd;
    logic       ivld;
    logic [7:0] id;
    logic       e_clr_cmd;
    logic       e_clr_id;
    logic       e_it;
    logic [5:0] e_dest;
    logic [2:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_cmd(input logic [1:0] op, input logic [5:0] d, input logic it,
                         input logic [5:0] ed, input logic [2:0] ec, input logic ovf);
    vq.push_back('{1'b1, {op, d}, 1'b0, 8'h00, 1'b1, 1'b0, it, ed, ec, ovf});
  endtask

  task automatic add_id(input logic [7:0] id, input logic it, input logic [5:0] ed,
                        input logic [2:0] ec);
    vq.push_back('{1'b0, 8'h00, 1'b1, id, 1'b0, 1'b1, it, ed, ec, 1'b0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_buzz, bad_n, hi_cnt;
    logic exp_b;

    rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; ID = '0; ID_vld = 1'b0; OK2Move = 1'b1;
    step();
    step();
    check("rst_in_transit", in_transit, 0);
    check("rst_q_cnt", q_cnt, 0);
    check("rst_dest_id", dest_id, 0);
    check("rst_buzz", {buzz, buzz_n}, 0);
    check("rst_q_ovf", q_ovf, 0);
    rst_n = 1'b1;
    step();

    // GOTO 5, pop with 5
    add_cmd(GOTO, 6'd5, 1, 6'd5, 1, 0);
    add_id(8'h05, 0, 6'd0, 0);
    // Multi-entry walk; upper ID bits must be ignored
    add_cmd(GOTO, 6'd3, 1, 6'd3, 1, 0);
    add_cmd(APND, 6'd7, 1, 6'd3, 2, 0);
    add_cmd(APND, 6'd9, 1, 6'd3, 3, 0);
    add_id(8'h03, 1, 6'd7, 2);
    add_id(8'h04, 1, 6'd7, 2);
    add_id(8'h07, 1, 6'd9, 1);
    add_id(8'hC9, 0, 6'd0, 0);
    // IDLE discards IDs; reserved opcode has no effect; APPEND to empty starts transit
    add_id(8'h09, 0, 6'd0, 0);
    add_cmd(RSVD, 6'd8, 0, 6'd0, 0, 0);
    add_cmd(APND, 6'd2, 1, 6'd2, 1, 0);
    add_id(8'h02, 0, 6'd0, 0);
    // Fill, overflow, drain in order
    add_cmd(GOTO, 6'd1, 1, 6'd1, 1, 0);
    add_cmd(APND, 6'd2, 1, 6'd1, 2, 0);
    add_cmd(APND, 6'd3, 1, 6'd1, 3, 0);
    add_cmd(APND, 6'd4, 1, 6'd1, 4, 0);
    add_cmd(APND, 6'd5, 1, 6'd1, 4, 1);
    add_id(8'h01, 1, 6'd2, 3);
    add_id(8'h02, 1, 6'd3, 2);
    add_id(8'h03, 1, 6'd4, 1);
    add_id(8'h04, 0, 6'd0, 0);
    // Fill from a non-zero base so both pointers wrap mid-queue
    add_cmd(APND, 6'd10, 1, 6'd10, 1, 0);
    add_cmd(APND, 6'd11, 1, 6'd10, 2, 0);
    add_id(8'h0A, 1, 6'd11, 1);
    add_cmd(APND, 6'd12, 1, 6'd11, 2, 0);
    add_cmd(APND, 6'd13, 1, 6'd11, 3, 0);
    add_cmd(APND, 6'd14, 1, 6'd11, 4, 0);
    add_cmd(APND, 6'd15, 1, 6'd11, 4, 1);
    add_id(8'h0B, 1, 6'd12, 3);
    add_id(8'h0C, 1, 6'd13, 2);
    add_id(8'h0D, 1, 6'd14, 1);
    add_id(8'h0E, 0, 6'd0, 0);
    // STOP mid-transit with three entries
    add_cmd(GOTO, 6'd1, 1, 6'd1, 1, 0);
    add_cmd(APND, 6'd2, 1, 6'd1, 2, 0);
    add_cmd(APND, 6'd3, 1, 6'd1, 3, 0);
    add_cmd(STOP, 6'd0, 0, 6'd0, 0, 0);

    foreach (vq[i]) begin
      cmd_rdy = vq[i].crdy; cmd = vq[i].cmd; ID_vld = vq[i].ivld; ID = vq[i].id;
      #1;
      check($sformatf("v%0d_clr_cmd_rdy", i), clr_cmd_rdy, vq[i].e_clr_cmd);
      check($sformatf("v%0d_clr_ID_vld", i), clr_ID_vld, vq[i].e_clr_id);
      step();
      cmd_rdy = 1'b0; ID_vld = 1'b0;
      check($sformatf("v%0d_in_transit", i), in_transit, vq[i].e_it);
      check($sformatf("v%0d_dest_id", i), dest_id, vq[i].e_dest);
      check($sformatf("v%0d_q_cnt", i), q_cnt, vq[i].e_cnt);
      check($sformatf("v%0d_q_ovf", i), q_ovf, vq[i].e_ovf);
    end

    // Command and ID together: command first, ID next cycle
    cmd = {GOTO, 6'd20}; cmd_rdy = 1'b1;
    step();
    cmd = {APND, 6'd21}; ID = 8'd20; ID_vld = 1'b1;
    #1;
    check("prio_clr_cmd", clr_cmd_rdy, 1);
    check("prio_clr_id_blocked", clr_ID_vld, 0);
    step();
    cmd_rdy = 1'b0;
    check("prio_cnt_after_cmd", q_cnt, 2);
    #1;
    check("prio_clr_id_next", clr_ID_vld, 1);
    step();
    ID_vld = 1'b0;
    check("prio_dest_after_pop", dest_id, 21);
    check("prio_cnt_after_pop", q_cnt, 1);

    // Buzzer: in transit, blocked for 30000 cycles
    check("buzz_idle_en0", {buzz, buzz_n}, 0);
    check("go_ok", go, 1);
    OK2Move = 1'b0;
    #1;
    check("go_blocked", go, 0);
    step();
    bad_buzz = 0; bad_n = 0; hi_cnt = 0;
    for (int k = 0; k < 30000; k++) begin
      exp_b = ((k % 12500) < 6250);
      if (buzz !== exp_b) bad_buzz++;
      if (buzz_n !== ~exp_b) bad_n++;
      if (k < 12500 && buzz === 1'b1) hi_cnt++;
      step();
    end
    check("buzz_wave_bad_cycles", bad_buzz, 0);
    check("buzz_n_bad_cycles", bad_n, 0);
    check("buzz_high_per_period", hi_cnt, 6250);
    OK2Move = 1'b1;
    step();
    check("buzz_off_after_ok", {buzz, buzz_n}, 0);
    check("go_resumed", go, 1);

    // Asynchronous reset mid-buzz
    OK2Move = 1'b0;
    repeat (10) step();
    check("buzz_before_rst", buzz, 1);
    #2;
    cmd = {APND, 6'd9}; cmd_rdy = 1'b1; ID = 8'd21; ID_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_in_transit", in_transit, 0);
    check("arst_go", go, 0);
    check("arst_buzz", {buzz, buzz_n}, 0);
    check("arst_q_cnt", q_cnt, 0);
    check("arst_dest_id", dest_id, 0);
    check("arst_q_ovf", q_ovf, 0);
    cmd_rdy = 1'b0; ID_vld = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_transit", in_transit, 0);
    check("post_rst_q_cnt", q_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
